// File: rtl/sensor_code_ctrl_if.sv
// Pin-side bundle for sensor_code_ctrl: raw sensor/mode in, debounced value,
// converted code, seven-segment digit, motor enable and change pulse out.
interface sensor_code_ctrl_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] sensor;
  logic [1:0]       mode;
  logic [WIDTH-1:0] sensor_q;
  logic [WIDTH:0]   code_out;
  logic [6:0]       seg7;
  logic             motor;
  logic             changed;

  modport master (
    output sensor, mode,
    input  sensor_q, code_out, seg7, motor, changed
  );

  modport slave (
    input  sensor, mode,
    output sensor_q, code_out, seg7, motor, changed
  );
endinterface

// File: rtl/sensor_code_ctrl.sv
// Sensor synchroniser/debouncer, binary/Gray/excess-3 converter, hex seven-segment
// driver and hysteresis motor FSM with cooldown. Macro SEG7_ACTIVE_LOW_EN inverts seg7.
module sensor_code_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ON_TH           = 6,
  parameter int OFF_TH          = 2,
  parameter int MIN_OFF         = 8
) (
  input logic               clk,
  input logic               rst_n,
  sensor_code_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int COOL_W = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;

  localparam logic [CNT_W-1:0]  DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_HIT   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(MIN_OFF - 1);
  localparam logic [WIDTH-1:0]  ON_TH_W   = WIDTH'(ON_TH);
  localparam logic [WIDTH-1:0]  OFF_TH_W  = WIDTH'(OFF_TH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } state_t;

  logic [WIDTH-1:0]  sync1_reg;
  logic [WIDTH-1:0]  sync2_reg;
  logic [WIDTH-1:0]  s_prev_reg;
  logic [CNT_W-1:0]  stable_cnt_reg;
  logic [WIDTH-1:0]  sensor_q_reg;
  logic              changed_reg;
  logic [WIDTH:0]    code_out_reg;
  logic [WIDTH:0]    code_next;
  state_t            state_reg;
  logic [COOL_W-1:0] cool_cnt_reg;
  logic              motor_reg;
  logic              accept;
  logic [3:0]        nibble;
  logic [6:0]        seg_hi;

  // Accept only a value that has been held steady long enough and actually differs.
  assign accept = (stable_cnt_reg == DEB_HIT) && (sync2_reg == s_prev_reg) &&
                  (sync2_reg != sensor_q_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      s_prev_reg     <= '0;
      stable_cnt_reg <= '0;
      sensor_q_reg   <= '0;
      changed_reg    <= 1'b0;
    end else begin
      sync1_reg   <= bus.sensor;
      sync2_reg   <= sync1_reg;
      s_prev_reg  <= sync2_reg;
      changed_reg <= accept;
      if (sync2_reg != s_prev_reg) begin
        stable_cnt_reg <= '0;
      end else if (stable_cnt_reg != DEB_MAX) begin
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      end
      if (accept) begin
        sensor_q_reg <= sync2_reg;
      end
    end
  end

  always_comb begin
    code_next = {1'b0, sensor_q_reg};
    case (bus.mode)
      2'd1:    code_next = {1'b0, sensor_q_reg ^ (sensor_q_reg >> 1)};
      2'd2:    code_next = {1'b0, sensor_q_reg} + (WIDTH+1)'(3);
      default: code_next = {1'b0, sensor_q_reg};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out_reg <= '0;
    end else begin
      code_out_reg <= code_next;
    end
  end

  // Narrow codes are zero-padded up to a full hex nibble.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      if (gi < WIDTH + 1) begin : g_bit
        assign nibble[gi] = code_out_reg[gi];
      end else begin : g_pad
        assign nibble[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    seg_hi = 7'b0111111;
    case (nibble)
      4'h0: seg_hi = 7'b0111111;
      4'h1: seg_hi = 7'b0000110;
      4'h2: seg_hi = 7'b1011011;
      4'h3: seg_hi = 7'b1001111;
      4'h4: seg_hi = 7'b1100110;
      4'h5: seg_hi = 7'b1101101;
      4'h6: seg_hi = 7'b1111101;
      4'h7: seg_hi = 7'b0000111;
      4'h8: seg_hi = 7'b1111111;
      4'h9: seg_hi = 7'b1101111;
      4'hA: seg_hi = 7'b1110111;
      4'hB: seg_hi = 7'b1111100;
      4'hC: seg_hi = 7'b0111001;
      4'hD: seg_hi = 7'b1011110;
      4'hE: seg_hi = 7'b1111001;
      default: seg_hi = 7'b1110001;
    endcase
  end

  // Hysteresis FSM; high readings during cooldown wait for the re-check in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cool_cnt_reg <= '0;
      motor_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sensor_q_reg >= ON_TH_W) begin
            state_reg <= RUN;
            motor_reg <= 1'b1;
          end
        end
        RUN: begin
          if (sensor_q_reg <= OFF_TH_W) begin
            state_reg    <= COOL;
            cool_cnt_reg <= COOL_LOAD;
            motor_reg    <= 1'b0;
          end
        end
        COOL: begin
          motor_reg <= 1'b0;
          if (cool_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cool_cnt_reg <= cool_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          motor_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sensor_q = sensor_q_reg;
  assign bus.code_out = code_out_reg;
  assign bus.motor    = motor_reg;
  assign bus.changed  = changed_reg;

`ifdef SEG7_ACTIVE_LOW_EN
  assign bus.seg7 = ~seg_hi;
`else
  assign bus.seg7 = seg_hi;
`endif

endmodule

// File: doc/sensor_code_ctrl.md
Name: sensor_code_ctrl

Overview:
- Parametrised, clocked successor of the sensor/motor/code-converter block.
- Takes a WIDTH-bit raw sensor word, synchronises and debounces it, and converts it to binary, Gray or excess-3 under a runtime mode select.
- Drives one seven-segment digit.
- Runs the motor through a hysteresis state machine with an enforced minimum off (cooldown) time.
- Sits between the board sensor pins and the display/motor pins.

Parameters:
- WIDTH, 3: sensor word width; legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before the sensor value is accepted; must be ≥1.
- ON_TH, 6: motor turns on when the accepted sensor value ≥ ON_TH.
- OFF_TH, 2: motor turns off when the accepted sensor value ≤ OFF_TH; must be < ON_TH.
- MIN_OFF, 8: cooldown cycles after turn-off before the motor may restart; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sensor  input  WIDTH  raw, asynchronous sensor word.
- mode  input  2  code select: 0 = binary, 1 = Gray, 2 = excess-3, 3 = binary.
- sensor_q  output  WIDTH  accepted (debounced) sensor value.
- code_out  output  WIDTH+1  converted code, zero-extended.
- seg7  output  7  segments {g,f,e,d,c,b,a}, showing the hex digit of code_out[3:0].
- motor  output  1  motor enable.
- changed  output  1  one-cycle pulse whenever sensor_q updates.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchroniser flops, s_prev, sensor_q, stable_cnt and code_out = 0.
  - changed = 0, motor = 0, FSM = IDLE.
  - seg7 = pattern for digit 0.
  - Reset mid-operation aborts any debounce count or cooldown immediately.
- Synchroniser: two flops; s = 2nd-stage output. s lags sensor by 2 clocks.
- Debounce:
  - s_prev <= s every cycle.
  - If s != s_prev, stable_cnt <= 0. Otherwise stable_cnt increments, saturating at DEBOUNCE_CYCLES.
  - When stable_cnt == DEBOUNCE_CYCLES-1, s == s_prev and s != sensor_q: sensor_q <= s and changed <= 1 for that one cycle.
  - Glitches shorter than DEBOUNCE_CYCLES never reach sensor_q.
  - A value equal to the current sensor_q never pulses changed.
- Conversion (registered, combinational from sensor_q and mode, one cycle after sensor_q):
  - Binary: code_out = sensor_q.
  - Gray: code_out = sensor_q ^ (sensor_q >> 1).
  - Excess-3: code_out = sensor_q + 3, computed in WIDTH+1 bits so there is no overflow.
  - A mode change is reflected on code_out the next cycle, with no debounce.
- seg7: combinational from code_out[3:0] (bit 3 = 0 when WIDTH+1 < 4). Standard hex font; examples: 0 = 0111111, 2 = 1011011, 5 = 1101101, 8 = 1111111, 9 = 1101111, A = 1110111, F = 1110001.
- Motor FSM (evaluated on sensor_q):
  - IDLE: motor=0. Go to RUN when sensor_q ≥ ON_TH.
  - RUN: motor=1. When sensor_q ≤ OFF_TH, go to COOL and load cool_cnt = MIN_OFF-1.
  - COOL: motor=0. cool_cnt decrements each cycle; at 0 go to IDLE.
  - Values ≥ ON_TH seen during COOL are ignored; the re-check happens in IDLE.
  - Values strictly between OFF_TH and ON_TH hold the current state.
  - motor is registered: it rises the cycle after sensor_q crosses ON_TH.
- Simultaneous events: a sensor_q update and a FSM transition in the same cycle are both taken. The FSM always sees the post-update sensor_q one cycle later.

Optional Feature:
- Macro: SEG7_ACTIVE_LOW_EN.
- Defined: seg7 is the bitwise inverse of the active-high pattern. Reset value = 1000000 (digit 0, active-low).
- Undefined: seg7 is active-high as specified above.
- All other outputs are unaffected either way.

Test Plan:
- Reset with sensor=3'b011 held → all outputs 0, seg7=0111111. After release, sensor_q=3 and changed pulses once, 2+4 cycles after release; code_out=3, motor=0.
- sensor=6, mode=0 held 10 cycles → sensor_q=6, code_out=6, motor=1 one cycle after sensor_q=6. mode=1 → code_out=5 (seg7=1101101). mode=2 → code_out=9 (seg7=1101111).
- From RUN, sensor=1 → motor=0 one cycle after sensor_q=1. Then sensor=7 immediately → motor stays 0 for 8 cooldown cycles, then returns to 1. mode=2 → code_out=10, seg7=1110111.
- 3-cycle glitch 0→7→0 on sensor → sensor_q stays 0, changed never pulses, motor stays 0.
- sensor=4 (between thresholds) from IDLE and from RUN → motor holds 0 and 1 respectively.
- rst_n low during COOL and mid-debounce → immediate return to reset values. Build with SEG7_ACTIVE_LOW_EN → seg7 reset value=1000000, digit 6 shown as 0000010.
